uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver, LSB first. Counterpart to the core's uart_tx.
- Oversamples the asynchronous rx line and validates the start bit.
- Recovers each bit by 3-sample majority vote at mid-bit.
- Delivers bytes through a single-entry valid/ready holding register, with framing-error and overrun pulses. Sits beside uart_tx in core as the host-to-core serial input.

Parameters:
- CLK_FREQ, 50_000_000: system clock in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit; must be even and ≥ 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- rx  in  1  asynchronous serial input; idle level is high.
- rx_data  out  8  received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts the byte when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: new byte dropped because the holding register was full.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Divider and tick
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated. Elaboration error if DIV < 1.
  - Tick counter runs 0..DIV-1. tick = 1 for one clk when the counter equals DIV-1.
  - Counter is cleared in IDLE, so tick phase is re-aligned at each start edge.
- Synchronizer
  - 2-FF synchronizer on rx, both flops reset to 1. Output is rx_s.
  - All decisions use rx_s. Pin-to-decision latency is 2 clk.
- Sample counter
  - sc counts 0..OVERSAMPLE-1, advancing on tick.
  - Samples are taken at sc = M-1, M, M+1, where M = OVERSAMPLE/2.
  - Vote = majority of the 3 samples, evaluated on the tick where sc = M+1.
- FSM: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s=0 → START, sc=0, tick counter=0.
  - START: at vote, vote=1 → IDLE (false start; no output activity). vote=0 → stay; on tick with sc=OVERSAMPLE-1 → DATA, bit index=0, sc=0.
  - DATA:
    - At vote, shift vote into bit[index] (LSB first).
    - On tick with sc=OVERSAMPLE-1: if index=7 → STOP, else index+1. sc wraps to 0.
  - STOP: at vote (mid-stop-bit), leave the state immediately; no full stop bit is waited.
    - vote=1 → deliver the byte, go to IDLE.
    - vote=0 → frame_err=1 for 1 clk, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: rx_s=1 → IDLE. A break condition therefore never re-triggers a start.
- Delivery (cycle after the STOP vote tick)
  - rx_valid=0 or rx_ready=1 in that cycle: rx_data ← byte, rx_valid=1.
  - Otherwise: overrun=1 for 1 clk; old rx_data and rx_valid=1 are kept; new byte dropped.
  - Acceptance and delivery in the same cycle: the old byte is consumed, the new byte is loaded, rx_valid stays 1.
  - Acceptance without delivery: rx_valid=0 on the next clk.
- Reset (at any time, including mid-frame)
  - State=IDLE, counters=0, shift register=0, partial byte discarded.
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - A line held low at reset release is detected as a start 2 clk after release.
- Width rules
  - Tick counter width: $clog2(DIV), minimum 1.
  - sc width: $clog2(OVERSAMPLE).
  - Bit index: 3 bits.

Decomposition:
- Package uart_pkg:
  - FSM state enum (shared style with uart_tx).
  - DATA_BITS=8.
  - Helper function computing DIV from CLK_FREQ/BAUD_RATE/OVERSAMPLE.
- Sub-module uart_baud_tick: parameter DIV; inputs clk, rst, clr; output tick. Reusable by uart_tx.
- Synchronizer and FSM stay inline in uart_rx.

Test Plan (CLK_FREQ=3_200_000, BAUD_RATE=100_000, OVERSAMPLE=16 → DIV=2, 32 clk/bit; rx_ready=1 unless stated):
- Frame 0xA5 with stop=1 → rx_valid=1 with rx_data=0xA5 about 9.5 bit times after the start edge; frame_err=0; busy returns to 0.
- Low glitch of 6 clk on idle line → START rejects by vote; rx_valid never asserts; busy=0 within 20 clk after glitch end.
- Frame 0x3C with stop bit low, line held low 200 clk → one frame_err pulse; rx_valid stays 0; no new start until the line is high, then 0x81 is received correctly.
- rx_ready=0, back-to-back frames 0x11 then 0x22 → rx_data=0x11 held; one overrun pulse at 0x22 delivery; raise rx_ready → rx_valid=0 next clk.
- rx_ready=1, back-to-back frames 0x11, 0x22, 0x33 → three deliveries in order, overrun=0 throughout.
- rst pulse mid-frame after bit 4 → all outputs 0 next clk; then frame 0x5A → rx_data=0x5A, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divider helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every DIV clocks, phase reset by clr.
module uart_baud_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Suppressed while cleared so the first tick lands DIV clocks after the start edge.
    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start validation, 3-sample mid-bit majority vote,
// single-entry valid/ready holding register with frame-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int M   = OVERSAMPLE / 2;
    localparam logic [SCW-1:0] SC_S0   = SCW'(M - 1);
    localparam logic [SCW-1:0] SC_S1   = SCW'(M);
    localparam logic [SCW-1:0] SC_VOTE = SCW'(M + 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_rx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE (DIV < 1)");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("uart_rx: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    uart_state_e          state, state_n;
    logic                 rx_m, rx_s;
    logic                 tick;
    logic [SCW-1:0]       sc;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 s0, s1, vote;
    logic                 vote_tick, last_tick;
    logic                 deliver_set, ferr_set, deliver_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_IDLE),
        .tick (tick)
    );

    // Third sample is the live synchronized line on the vote tick.
    assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign vote_tick = tick && (sc == SC_VOTE);
    assign last_tick = tick && (sc == SC_LAST);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        deliver_set = 1'b0;
        ferr_set    = 1'b0;
        case (state)
            ST_IDLE:      if (!rx_s) state_n = ST_START;
            ST_START: begin
                if (vote_tick && vote) state_n = ST_IDLE;
                else if (last_tick)    state_n = ST_DATA;
            end
            ST_DATA:      if (last_tick && idx == IDX_LAST) state_n = ST_STOP;
            ST_STOP: begin
                if (vote_tick) begin
                    if (vote) begin
                        state_n     = ST_IDLE;
                        deliver_set = 1'b1;
                    end else begin
                        state_n  = ST_WAIT_HIGH;
                        ferr_set = 1'b1;
                    end
                end
            end
            ST_WAIT_HIGH: if (rx_s) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sc        <= '0;
            idx       <= '0;
            shreg     <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            deliver_q <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            deliver_q <= deliver_set;
            frame_err <= ferr_set;
            if (state == ST_IDLE) begin
                sc  <= '0;
                idx <= '0;
            end else if (tick) begin
                sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
                if (sc == SC_S0) s0 <= rx_s;
                if (sc == SC_S1) s1 <= rx_s;
                if (state == ST_DATA && sc == SC_VOTE) shreg[idx] <= vote;
                if (state == ST_DATA && sc == SC_LAST) idx <= idx + 1'b1;
            end
        end
    end

    // Holding register: a new byte may replace one being accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame table plus hand-written corner sequences, byte scoreboard.
module tb_uart_rx;

    localparam int BIT_CLK = 32;

    logic       clk, rst, rx, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;

    uart_rx #(
        .CLK_FREQ   (3_200_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_ferr;
    } vec_t;

    vec_t       tbl[5];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    bit         lat_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: scoreboard an accepted byte and count pulses, then advance to the next negedge.
    task automatic step();
        logic [7:0] e;
        int         lat;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %02h expected none", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL byte: got %02h expected %02h", rx_data, e);
                end
            end
            if (lat_en) begin
                lat = cyc - start_cyc;
                checks++;
                if (lat < 300 || lat > 330) begin
                    errors++;
                    $display("FAIL latency: got %0d clk expected 300..330", lat);
                end
            end
        end
        if (frame_err === 1'b1) n_ferr++;
        if (overrun === 1'b1)   n_ovr++;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Start, 8 data bits LSB first, stop; the line is left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        rx = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(BIT_CLK);
        end
        rx = stop;
        idle(BIT_CLK);
    endtask

    initial begin
        int f0, o0;

        tbl[0] = '{8'hA5, 1'b1, 0};
        tbl[1] = '{8'h00, 1'b1, 0};
        tbl[2] = '{8'hFF, 1'b1, 0};
        tbl[3] = '{8'h3C, 1'b0, 1};
        tbl[4] = '{8'h81, 1'b1, 0};

        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
        idle(3);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        idle(10);

        // Table frames, line returns high after each stop bit
        lat_en = 1'b1;
        foreach (tbl[k]) begin
            f0 = n_ferr;
            if (tbl[k].stop) exp_q.push_back(tbl[k].data);
            send_frame(tbl[k].data, tbl[k].stop);
            rx = 1'b1;
            idle(40);
            chk($sformatf("tbl%0d_ferr", k), n_ferr - f0, tbl[k].exp_ferr);
            chk($sformatf("tbl%0d_pending", k), exp_q.size(), 0);
            chk($sformatf("tbl%0d_busy", k), busy, 0);
        end
        lat_en = 1'b0;

        // 6-clk low glitch must be rejected by the start vote
        rx = 1'b0;
        idle(6);
        rx = 1'b1;
        chk("glitch_busy_mid", busy, 1);
        idle(20);
        chk("glitch_busy_end", busy, 0);
        chk("glitch_valid", rx_valid, 0);
        idle(20);

        // Framing error followed by a long break, then recovery
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        idle(200);
        chk("break_ferr", n_ferr - f0, 1);
        chk("break_valid", rx_valid, 0);
        chk("break_busy", busy, 1);
        rx = 1'b1;
        idle(20);
        chk("break_idle", busy, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(20);
        chk("break_pending", exp_q.size(), 0);
        chk("break_ferr_after", n_ferr - f0, 1);

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        o0 = n_ovr;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(20);
        chk("ovr_valid", rx_valid, 1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_pulses", n_ovr - o0, 1);
        rx_ready = 1'b1;
        step();
        chk("ovr_accept_valid", rx_valid, 0);
        chk("ovr_pending", exp_q.size(), 0);
        idle(10);

        // Back-to-back frames with the consumer always ready
        o0 = n_ovr;
        f0 = n_ferr;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        idle(20);
        chk("b2b_pending", exp_q.size(), 0);
        chk("b2b_overrun", n_ovr - o0, 0);
        chk("b2b_ferr", n_ferr - f0, 0);

        // Reset in the middle of a frame, after bit 4
        rx = 1'b0;
        idle(BIT_CLK);
        for (int i = 0; i < 5; i++) begin
            rx = i[0];
            idle(BIT_CLK);
        end
        chk("midrst_busy_before", busy, 1);
        rst = 1'b1;
        rx  = 1'b1;
        step();
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        idle(10);
        f0 = n_ferr;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(20);
        chk("midrst_pending", exp_q.size(), 0);
        chk("midrst_ferr", n_ferr - f0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
